state_queue: RTL and testbench
==============================

STATE_QUEUE -- requirements
Module: state_queue

Interface
REQ-001 SHALL have parameter NC, default 7: number of neurons in the producing layer.
REQ-002 SHALL have parameter WF, default 5: bits per neuron value.
REQ-003 SHALL have parameter DEPTH, default 4: number of stored state vectors; any value of 2 or more, not only powers of two.
REQ-004 SHALL have parameter BURST, default "yes": "yes" allows a push into a full queue in the same cycle as a pop; "no" does not.
REQ-005 SHALL have port iCLK, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port iRST, input, width 1: synchronous, active-high reset.
REQ-007 SHALL have port iMode, input, width 1: 1 = training (store), 0 = inference (discard).
REQ-008 SHALL have port iValid_AM_State1, input, width 1: producer valid.
REQ-009 SHALL have port oReady_AM_State1, output, width 1: producer ready.
REQ-010 SHALL have port iData_AM_State1, input, width NC*WF: activation vector; neuron i occupies bits [i*WF +: WF].
REQ-011 SHALL have port oValid_BM_State1, output, width 1: consumer valid.
REQ-012 SHALL have port iReady_BM_State1, input, width 1: consumer ready.
REQ-013 SHALL have port oData_BM_State1, output, width NC*WF: head-of-queue vector.
REQ-014 SHALL have port oLevel, output, width $clog2(DEPTH+1): current occupancy.

Function
REQ-015 Push SHALL occur when iValid_AM_State1, oReady_AM_State1 and iMode are all 1; pop SHALL occur when oValid_BM_State1 and iReady_BM_State1 are both 1.
REQ-016 With iMode=0, oReady_AM_State1 SHALL be 1 and accepted vectors SHALL be discarded without changing oLevel; pops SHALL continue normally.
REQ-017 With iMode=1 and BURST="yes", oReady_AM_State1 SHALL be (oLevel<DEPTH) OR iReady_BM_State1.
REQ-018 With iMode=1 and BURST="no", oReady_AM_State1 SHALL be (oLevel<DEPTH).
REQ-019 oValid_BM_State1 SHALL equal (oLevel!=0) and SHALL NOT depend combinationally on iValid_AM_State1.
REQ-020 Latency: a vector pushed into an empty queue at edge N SHALL appear on oData_BM_State1 with oValid_BM_State1=1 after edge N; there is no combinational bypass.
REQ-021 Order SHALL be strict FIFO with bit-exact data, no arithmetic and no width change.
REQ-022 Write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-023 oLevel SHALL increase by 1 on push-only, decrease by 1 on pop-only, and stay unchanged on simultaneous push and pop, including at full (BURST="yes") and at empty-plus-one.
REQ-024 oData_BM_State1 SHALL hold its value while oValid_BM_State1=1 and iReady_BM_State1=0.
REQ-025 A change of iMode SHALL NOT alter stored contents or oLevel.
REQ-026 Pop when empty and push when not ready SHALL be impossible by construction, and SHALL leave state unchanged.

Reset
REQ-027 While iRST=1 at a clock edge: oLevel=0, both pointers=0, oValid_BM_State1=0, oData_BM_State1=0; storage contents are don't-care.
REQ-028 oReady_AM_State1 SHALL be 1 during reset and the cycle after it.
REQ-029 Reset mid-operation SHALL discard all entries, and no stale vector SHALL be presented afterwards.

Structure
REQ-030 The shared network package SHALL hold the vector-slice width rule (NC*WF) and the level-width function $clog2(DEPTH+1).
REQ-031 Storage SHALL be one sub-module, state_ram (DEPTH x NC*WF, 1 write port, 1 registered read port); pointer, level and handshake logic stay in state_queue.

Verification (NC=2, WF=4, DEPTH=4)
REQ-032 Push 0x12 into an empty queue with iReady_BM=0 -> next cycle oValid=1, oData=0x12, oLevel=1.
REQ-033 Push 0x01, 0x02, 0x03, 0x04 with iReady_BM=0 -> oLevel=4; BURST="no" gives oReady=0; then pop all -> 0x01..0x04 in order, oLevel=0, oValid=0.
REQ-034 BURST="yes", full, iValid=iReady_BM=1 for 8 cycles with data 0x10..0x17 -> oLevel stays 4, outputs 0x01..0x04 then 0x10..0x13.
REQ-035 iMode=0, push 0xAA -> oReady=1, oLevel unchanged, 0xAA never appears on output.
REQ-036 oLevel=3, assert iRST for 1 cycle -> oValid=0, oData=0, oLevel=0; then push 0x55 -> output 0x55 first.
REQ-037 Random valid/ready at 50% each, 10k cycles, scoreboard -> no loss, duplication or reordering; oLevel never exceeds 4.

Source files
------------

// File: rtl/state_queue_pkg.sv
// Shared network definitions for the state queue: vector width rule,
// occupancy width rule and the per-cycle queue operation encoding.
package state_queue_pkg;

  // Width of one activation vector: NC neurons of WF bits each.
  function automatic int unsigned vec_w(input int unsigned nc, input int unsigned wf);
    return nc * wf;
  endfunction

  // Width needed to count 0..DEPTH entries inclusive.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Queue operation for a cycle, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage

// File: rtl/state_ram.sv
// Vector storage for the state queue: one write port and one registered
// read port. A write to the address being read appears on the read register
// in the same cycle so a freshly pushed head is visible right after its edge.
module state_ram #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 35,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read with write-through on address collision.
  always_ff @(posedge clk) begin
    if (rst)                      rdata <= '0;
    else if (we && waddr == raddr) rdata <= wdata;
    else                          rdata <= mem[raddr];
  end

endmodule

// File: rtl/state_queue.sv
// FIFO of neuron state vectors between a producing and a consuming layer.
// In training mode accepted vectors are stored; in inference mode they are
// accepted and dropped. Pointer, level and handshake logic live here; the
// vectors themselves live in state_ram.
module state_queue
  import state_queue_pkg::*;
#(
  parameter int unsigned NC    = 7,
  parameter int unsigned WF    = 5,
  parameter int unsigned DEPTH = 4,
  parameter string       BURST = "yes"
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iMode,
  input  logic                      iValid_AM_State1,
  output logic                      oReady_AM_State1,
  input  logic [vec_w(NC,WF)-1:0]   iData_AM_State1,
  output logic                      oValid_BM_State1,
  input  logic                      iReady_BM_State1,
  output logic [vec_w(NC,WF)-1:0]   oData_BM_State1,
  output logic [lvl_w(DEPTH)-1:0]   oLevel
);

  localparam int unsigned W  = vec_w(NC, WF);
  localparam int unsigned LW = lvl_w(DEPTH);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam bit          BURST_EN = (BURST == "yes");
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr, rd_next, wr_next;
  logic [LW-1:0] level;
  logic          push, pop, room;
  logic [W-1:0]  head;
  op_e           op;

  function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Handshake decode and next read pointer.
  always_comb begin
    room             = (level != FULL);
    oValid_BM_State1 = (level != '0);
    pop              = oValid_BM_State1 && iReady_BM_State1;
    if (iRST)          oReady_AM_State1 = 1'b1;
    else if (!iMode)   oReady_AM_State1 = 1'b1;
    else if (BURST_EN) oReady_AM_State1 = room || iReady_BM_State1;
    else               oReady_AM_State1 = room;
    push    = iValid_AM_State1 && oReady_AM_State1 && iMode;
    op      = op_e'({push, pop});
    rd_next = pop  ? inc_ptr(rd_ptr) : rd_ptr;
    wr_next = push ? inc_ptr(wr_ptr) : wr_ptr;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      case (op)
        OP_PUSH: level <= level + 1'b1;
        OP_POP:  level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // The RAM reads the slot that will be head after this edge, so the read
  // register always holds the current head once the edge has passed.
  state_ram #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_ram (
    .clk   (iCLK),
    .rst   (iRST),
    .we    (push && !iRST),
    .waddr (wr_ptr),
    .wdata (iData_AM_State1),
    .raddr (rd_next),
    .rdata (head)
  );

  // Slots left behind by pops or a reset are never shown.
  assign oData_BM_State1 = oValid_BM_State1 ? head : '0;
  assign oLevel          = level;

endmodule

// File: tb/tb_state_queue.sv
// Directed and scoreboard checks for state_queue with NC=2, WF=4, DEPTH=4.
// Two instances share stimulus: one with BURST="yes", one with BURST="no".
module tb_state_queue;

  localparam int unsigned W  = 8;
  localparam int unsigned LW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, mode, valid, rdy_bm;
  logic [W-1:0]  din;
  logic          ready, ovalid;
  logic [W-1:0]  dout;
  logic [LW-1:0] level;
  logic          ready_nb, ovalid_nb;
  logic [W-1:0]  dout_nb;
  logic [LW-1:0] level_nb;

  int n_tests = 0;
  int n_fail  = 0;

  state_queue #(.NC(2), .WF(4), .DEPTH(4), .BURST("yes")) u_dut (
    .iCLK             (clk),
    .iRST             (rst),
    .iMode            (mode),
    .iValid_AM_State1 (valid),
    .oReady_AM_State1 (ready),
    .iData_AM_State1  (din),
    .oValid_BM_State1 (ovalid),
    .iReady_BM_State1 (rdy_bm),
    .oData_BM_State1  (dout),
    .oLevel           (level)
  );

  state_queue #(.NC(2), .WF(4), .DEPTH(4), .BURST("no")) u_dut_nb (
    .iCLK             (clk),
    .iRST             (rst),
    .iMode            (mode),
    .iValid_AM_State1 (valid),
    .oReady_AM_State1 (ready_nb),
    .iData_AM_State1  (din),
    .oValid_BM_State1 (ovalid_nb),
    .iReady_BM_State1 (rdy_bm),
    .oData_BM_State1  (dout_nb),
    .oLevel           (level_nb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [W-1:0] d);
    valid = 1'b1;
    din   = d;
    step();
    valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [W-1:0] exp_q [$];
  logic [W-1:0] burst_exp [8];
  logic         exp_ready, exp_valid;

  initial begin
    rst = 1'b1; mode = 1'b1; valid = 1'b0; rdy_bm = 1'b0; din = '0;

    // Reset state
    step(); step();
    check("rst_level", 32'(level), 0);
    check("rst_valid", 32'(ovalid), 0);
    check("rst_data", 32'(dout), 0);
    check("rst_ready", 32'(ready), 1);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(ready), 1);

    // Single push into empty queue
    push_one(8'h12);
    check("first_valid", 32'(ovalid), 1);
    check("first_data", 32'(dout), 32'h12);
    check("first_level", 32'(level), 1);
    step();
    check("first_hold", 32'(dout), 32'h12);
    rdy_bm = 1'b1;
    step();
    rdy_bm = 1'b0;
    check("first_pop_level", 32'(level), 0);
    check("first_pop_valid", 32'(ovalid), 0);

    // Fill to full, then drain
    for (int unsigned i = 0; i < 4; i++) push_one(8'(i + 1));
    #1;
    check("full_level", 32'(level), 4);
    check("full_level_nb", 32'(level_nb), 4);
    check("full_ready_nb", 32'(ready_nb), 0);
    check("full_ready", 32'(ready), 0);
    rdy_bm = 1'b1;
    #1;
    check("full_ready_burst", 32'(ready), 1);
    check("full_ready_nb_rdy", 32'(ready_nb), 0);
    for (int unsigned i = 0; i < 4; i++) begin
      check("drain_data", 32'(dout), 32'(i + 1));
      step();
    end
    rdy_bm = 1'b0;
    check("drain_level", 32'(level), 0);
    check("drain_valid", 32'(ovalid), 0);

    // Burst through a full queue
    for (int unsigned i = 0; i < 4; i++) push_one(8'(i + 1));
    for (int unsigned i = 0; i < 4; i++) burst_exp[i] = 8'(i + 1);
    for (int unsigned i = 0; i < 4; i++) burst_exp[i + 4] = 8'(8'h10 + i);
    rdy_bm = 1'b1;
    valid  = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      din = 8'(8'h10 + i);
      #1;
      check("burst_data", 32'(dout), 32'(burst_exp[i]));
      step();
      check("burst_level", 32'(level), 4);
    end
    valid = 1'b0; rdy_bm = 1'b0;
    do_reset();

    // Reset mid-operation
    push_one(8'h21); push_one(8'h22); push_one(8'h23);
    check("pre_rst_level", 32'(level), 3);
    do_reset();
    check("mid_rst_valid", 32'(ovalid), 0);
    check("mid_rst_data", 32'(dout), 0);
    check("mid_rst_level", 32'(level), 0);
    push_one(8'h55);
    check("after_rst_data", 32'(dout), 32'h55);
    check("after_rst_level", 32'(level), 1);
    do_reset();

    // Inference mode discards, stored content survives mode change
    push_one(8'h31);
    mode = 1'b0;
    valid = 1'b1; din = 8'hAA;
    #1;
    check("inf_ready", 32'(ready), 1);
    step();
    valid = 1'b0;
    check("inf_level", 32'(level), 1);
    check("inf_data", 32'(dout), 32'h31);
    mode = 1'b1;
    rdy_bm = 1'b1;
    step();
    rdy_bm = 1'b0;
    check("inf_pop_level", 32'(level), 0);
    check("inf_pop_valid", 32'(ovalid), 0);
    check("inf_no_aa", 32'(dout), 0);

    // Random traffic against a scoreboard
    do_reset();
    exp_q.delete();
    for (int unsigned c = 0; c < 10000; c++) begin
      valid  = ($urandom_range(0, 1) == 1);
      rdy_bm = ($urandom_range(0, 1) == 1);
      din    = 8'($urandom_range(0, 255));
      #1;
      exp_ready = (exp_q.size() < 4) || rdy_bm;
      exp_valid = (exp_q.size() != 0);
      check("rnd_ready", 32'(ready), 32'(exp_ready));
      check("rnd_valid", 32'(ovalid), 32'(exp_valid));
      if (exp_valid && rdy_bm) begin
        check("rnd_data", 32'(dout), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (valid && exp_ready) exp_q.push_back(din);
      step();
      check("rnd_level", 32'(level), 32'(exp_q.size()));
      check("rnd_level_max", 32'(level <= 3'd4), 1);
    end
    valid = 1'b0; rdy_bm = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
